uart_cnt_reporter: RTL and testbench

- Transmit-side counterpart to the RX-FIFO command path.
- On request, snapshots the 14-bit up-counter value and converts it to four ASCII decimal digits.
- Streams the frame "DDDD\r\n" byte-by-byte into the uart transmitter through its start/tx_done handshake.
- Sits between U_upcounter qout and the uart tx_data/start inputs.

---
 rtl/uart_report_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 66 ++++++
 rtl/uart_cnt_reporter.sv | 158 +++++++++++++++
 tb/tb_uart_cnt_reporter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_report_pkg.sv
// uart_report_pkg
//   Shared constants and helpers for the counter-to-UART report path.
//   - FSM state codes for uart_cnt_reporter (IDLE, LOAD, CONV, SEND, WAIT)
//   - ASCII constants and frame length for the "DDDD\r\n" frame
//   - bcd_adjust: add-3 step of the double-dabble conversion
//   - frame_byte: byte index + BCD value -> ASCII byte of the frame
package uart_report_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CONV = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int FRAME_LEN   = 6;
  localparam int CNT_MAX_DEF = 9999;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Byte idx of the frame: four digits thousands-first, then CR, LF.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] bcd);
    logic [7:0] b;
    case (idx)
      3'd0:    b = ASCII_ZERO + {4'h0, bcd[15:12]};
      3'd1:    b = ASCII_ZERO + {4'h0, bcd[11:8]};
      3'd2:    b = ASCII_ZERO + {4'h0, bcd[7:4]};
      3'd3:    b = ASCII_ZERO + {4'h0, bcd[3:0]};
      3'd4:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble: W-bit binary in, 16-bit BCD out.
//   Ports:
//     clk      system clock
//     reset    asynchronous active-low reset
//     start_i  one-cycle pulse, captures bin_i
//     bin_i    binary value to convert
//     done_o   one-cycle pulse, ITER cycles after start_i; bcd_o valid from then on
//     bcd_o    converted value, held until the next start_i
//   The capture edge already performs the first shift (BCD is all zero then, so
//   no add-3 is needed); the remaining ITER-1 shifts run on the following edges.
module bin2bcd_seq
  import uart_report_pkg::*;
#(
  parameter int W    = 14,
  parameter int ITER = W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [W-1:0]  bin_i,
  output logic          done_o,
  output logic [15:0]   bcd_o
);

  localparam int CW = $clog2(ITER + 1);

  logic [W-1:0]  bin_q;
  logic [15:0]   bcd_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          done_q;
  logic [15:0]   bcd_adj;

  assign bcd_adj = bcd_adjust(bcd_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= {bin_i[W-2:0], 1'b0};
      bcd_q  <= {15'h0, bin_i[W-1]};
      cnt_q  <= CW'(ITER - 1);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      bin_q <= {bin_q[W-2:0], 1'b0};
      bcd_q <= {bcd_adj[14:0], bin_q[W-1]};
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_cnt_reporter.sv
// uart_cnt_reporter
//   Snapshots a binary counter, converts it to four decimal digits and streams
//   the frame "DDDD\r\n" into a UART transmitter via its start / tx_done handshake.
//   Optional build macro: UART_CNT_REPORTER_AUTO_EN adds a free-running period
//   counter (parameter AUTO_PERIOD) that raises a report request on every wrap.
//   Ports:
//     clk           system clock
//     reset         asynchronous active-low reset
//     i_report_req  one-cycle request for a report frame
//     i_count       live counter value (binary)
//     i_tx_done     one-cycle pulse from the UART when a byte has gone out
//     o_tx_start    one-cycle pulse launching one UART byte
//     o_tx_data     byte to send, held from o_tx_start until i_tx_done
//     o_busy        high whenever not IDLE
//     o_req_drop    one-cycle pulse when a request is discarded
//
//   state | meaning
//   IDLE  | waiting for a request or a pending request
//   LOAD  | capture min(i_count, CNT_MAX) into the converter
//   CONV  | double-dabble running, wait for converter done
//   SEND  | o_tx_start high for the current byte
//   WAIT  | byte in flight, wait for i_tx_done
module uart_cnt_reporter
  import uart_report_pkg::*;
#(
  parameter int CNT_W       = 14,
  parameter int CNT_MAX     = CNT_MAX_DEF,
  parameter int CONV_CYCLES = 14
`ifdef UART_CNT_REPORTER_AUTO_EN
  ,
  parameter int AUTO_PERIOD = 100_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_report_req,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_tx_done,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  output logic             o_busy,
  output logic             o_req_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);
  localparam logic [2:0]       IDX_LAST  = 3'(FRAME_LEN - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic [7:0]       data_q, data_d;

  logic             req;
  logic             conv_start;
  logic             conv_done;
  logic [15:0]      bcd;
  logic [CNT_W-1:0] count_sat;

`ifdef UART_CNT_REPORTER_AUTO_EN
  logic [31:0] per_q;
  logic        auto_req;

  assign auto_req = (per_q == 32'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) per_q <= '0;
    else        per_q <= auto_req ? '0 : per_q + 32'd1;
  end

  assign req = i_report_req | auto_req;
`else
  assign req = i_report_req;
`endif

  assign count_sat  = (i_count > CNT_MAX_V) ? CNT_MAX_V : i_count;
  assign conv_start = (state_q == ST_LOAD);

  // The converter's input register is the frame snapshot: it is loaded on
  // the LOAD edge and untouched until the next frame.
  bin2bcd_seq #(
    .W    (CNT_W),
    .ITER (CONV_CYCLES)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (count_sat),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    data_d  = data_q;

    if (req && (state_q != ST_IDLE)) begin
      if (pend_q) drop_d = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req || pend_q) begin
          state_d = ST_LOAD;
          // A fresh request arriving while a pending one is consumed stays pending.
          pend_d  = pend_q & req;
        end
      end
      ST_LOAD: state_d = ST_CONV;
      ST_CONV: begin
        if (conv_done) begin
          state_d = ST_SEND;
          idx_d   = 3'd0;
          data_d  = frame_byte(3'd0, bcd);
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
            idx_d   = idx_q + 3'd1;
            data_d  = frame_byte(idx_q + 3'd1, bcd);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
    end
  end

  assign o_tx_start = (state_q == ST_SEND);
  assign o_tx_data  = data_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_req_drop = drop_q;

endmodule

// File: tb/tb_uart_cnt_reporter.sv
module tb_uart_cnt_reporter;

  logic        clk;
  logic        reset;
  logic        i_report_req;
  logic [13:0] i_count;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_req_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int  start_cyc[$];
  int  nstarts = 0;
  int  drops = 0;
  int  dones = 0;
  int  ack_delay = 10;
  int  ack_cnt = 0;
  logic [7:0] held = 8'h00;

  uart_cnt_reporter dut (
    .clk          (clk),
    .reset        (reset),
    .i_report_req (i_report_req),
    .i_count      (i_count),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_req_drop   (o_req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: the frame is the saturated value as four decimal digits plus CR LF.
  task automatic expect_frame(input int count);
    int v;
    v = (count > 9999) ? 9999 : count;
    exp_q.push_back(8'(32'h30 + v / 1000));
    exp_q.push_back(8'(32'h30 + (v / 100) % 10));
    exp_q.push_back(8'(32'h30 + (v / 10) % 10));
    exp_q.push_back(8'(32'h30 + v % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART transmitter model: acknowledges each byte ack_delay cycles after its start.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (!reset) begin
        ack_cnt = 0;
      end else if (ack_cnt > 0) begin
        chk("data_stable", int'(o_tx_data), int'(held));
        ack_cnt--;
        if (ack_cnt == 0) begin
          i_tx_done = 1'b1;
          dones++;
        end
      end
      if (o_tx_start && reset) begin
        held    = o_tx_data;
        ack_cnt = ack_delay;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (o_req_drop) drops++;
      if (o_tx_start) begin
        start_cyc.push_back(cyc);
        nstarts++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %02h expected none", o_tx_data);
        end else begin
          chk("frame_byte", int'(o_tx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic pulse_req(output int rc);
    @(posedge clk); #2;
    rc = cyc;
    i_report_req = 1'b1;
    @(posedge clk); #2;
    i_report_req = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while ((nstarts < target || o_busy) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL timeout starts %0d expected %0d", nstarts, target);
    end
  endtask

  task automatic run_frame(input int count, input int delay);
    int rc;
    int n0;
    i_count   = 14'(count);
    ack_delay = delay;
    n0 = nstarts;
    expect_frame(count);
    pulse_req(rc);
    wait_frames(n0 + 6);
  endtask

  initial begin
    int rc, n0, d0, t;
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, n0, d0, t;
    reset = 1'b0;
    i_report_req = 1'b0;
    i_count = 14'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_start", int'(o_tx_start), 0);
    chk("rst_data", int'(o_tx_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_drop", int'(o_req_drop), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1234: latency and busy release
    i_count = 14'd1234;
    ack_delay = 10;
    n0 = nstarts;
    d0 = dones;
    expect_frame(1234);
    pulse_req(rc);
    t = 0;
    while (nstarts == n0 && t < 100) begin @(posedge clk); #2; t++; end
    chk("latency", (nstarts > n0) ? start_cyc[n0] - rc : -1, 16);
    t = 0;
    while (dones < d0 + 6 && t < 500) begin @(negedge clk); t++; end
    chk("busy_at_last_done", int'(o_busy), 1);
    @(negedge clk);
    chk("busy_after_last_done", int'(o_busy), 0);
    wait_frames(n0 + 6);

    run_frame(0, 10);
    run_frame(12000, 10);

    // three requests during one frame
    i_count = 14'd4321;
    ack_delay = 6;
    n0 = nstarts;
    d0 = drops;
    expect_frame(4321);
    expect_frame(4321);
    pulse_req(rc);
    repeat (4) @(posedge clk);
    pulse_req(rc);
    repeat (6) @(posedge clk);
    pulse_req(rc);
    wait_frames(n0 + 12);
    repeat (20) @(posedge clk);
    chk("drop_count", drops - d0, 1);
    chk("bytes_12", nstarts - n0, 12);

    // counter change during byte 1 does not alter the frame
    i_count = 14'd5678;
    ack_delay = 8;
    n0 = nstarts;
    expect_frame(5678);
    pulse_req(rc);
    t = 0;
    while (nstarts < n0 + 2 && t < 200) begin @(posedge clk); #2; t++; end
    i_count = 14'd9;
    wait_frames(n0 + 6);

    // reset during WAIT of byte 2
    i_count = 14'd2222;
    ack_delay = 10;
    n0 = nstarts;
    expect_frame(2222);
    pulse_req(rc);
    t = 0;
    while (nstarts < n0 + 3 && t < 200) begin @(posedge clk); #2; t++; end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_start", int'(o_tx_start), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_data", int'(o_tx_data), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    chk("no_start_after_abort", nstarts - n0, 3);
    run_frame(2222, 10);

    // randomized frames
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_frame(int'($urandom_range(0, 16383)), int'($urandom_range(1, 20)));
    end
    run_frame(9999, 3);
    run_frame(10000, 3);

    repeat (10) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
